fetch_queue: RTL and testbench

Dual-issue instruction fetch queue between instruction memory and the two decode slots of the superscalar datapath. It accepts up to two (PC, instruction) pairs per cycle from the fetch side and presents the two oldest entries, in program order, to decode slot 1 and slot 2. It absorbs decode stalls and discards all contents on a branch/jump flush.

---
 rtl/fetch_queue_pkg.sv | 14 +
 rtl/fq_ptr_ctrl.sv | 77 +++++++
 rtl/fetch_queue.sv | 86 ++++++++
 tb/tb_fetch_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the dual-issue fetch queue: default depth, datapath widths
// and the {pc, instr} entry layout.
package fetch_queue_pkg;

    localparam int FQ_DEPTH = 8;
    localparam int DWIDTH   = 32;
    localparam int PC_WIDTH = 32;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [DWIDTH-1:0]   instr;
    } fq_entry_t;

endpackage

// File: rtl/fq_ptr_ctrl.sv
// Read/write pointer and occupancy bookkeeping for the fetch queue: push, pop,
// flush and modulo-DEPTH wrap.
module fq_ptr_ctrl
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid_1,
    input  logic          i_valid_2,
    input  logic          i_pop_1,
    input  logic          i_pop_2,
    input  logic          i_flush,
    output logic [AW-1:0] o_rd_ptr,
    output logic [AW-1:0] o_wr_ptr,
    output logic [AW:0]   o_count,
    output logic          o_ready,
    output logic          o_push_1,
    output logic          o_push_2
);

    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          w_ready;
    logic [1:0]    w_push_n;
    logic [1:0]    w_pop_n;

    // Ready looks only at the registered count; same-cycle pops are not credited.
    assign w_ready  = (r_count <= (AW+1)'(DEPTH - 2));
    assign o_push_1 = w_ready & i_valid_1;
    assign o_push_2 = w_ready & i_valid_1 & i_valid_2;

    always_comb begin
        w_push_n = 2'd0;
        w_pop_n  = 2'd0;
        if (o_push_2) begin
            w_push_n = 2'd2;
        end else if (o_push_1) begin
            w_push_n = 2'd1;
        end
        // A paired pop is all-or-nothing: it needs both head entries present.
        if (i_pop_1 && i_pop_2) begin
            if (r_count >= (AW+1)'(2)) begin
                w_pop_n = 2'd2;
            end
        end else if (i_pop_1) begin
            if (r_count != '0) begin
                w_pop_n = 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + AW'(w_pop_n);
            r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
            r_count  <= r_count + (AW+1)'(w_push_n) - (AW+1)'(w_pop_n);
        end
    end

    assign o_rd_ptr = r_rd_ptr;
    assign o_wr_ptr = r_wr_ptr;
    assign o_count  = r_count;
    assign o_ready  = w_ready;

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue: circular {pc, instr} storage feeding the two
// decode slots in program order, with stall absorption and flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH  = FQ_DEPTH,
    parameter int IWIDTH = DWIDTH,
    parameter int PWIDTH = PC_WIDTH
) (
    input  logic                     fq_clk,
    input  logic                     fq_rst,
    input  logic                     fq_i_valid_1,
    input  logic                     fq_i_valid_2,
    input  logic [IWIDTH-1:0]        fq_i_instr_1,
    input  logic [IWIDTH-1:0]        fq_i_instr_2,
    input  logic [PWIDTH-1:0]        fq_i_pc_1,
    input  logic [PWIDTH-1:0]        fq_i_pc_2,
    output logic                     fq_o_ready,
    output logic                     fq_o_valid_1,
    output logic                     fq_o_valid_2,
    output logic [IWIDTH-1:0]        fq_o_instr_1,
    output logic [IWIDTH-1:0]        fq_o_instr_2,
    output logic [PWIDTH-1:0]        fq_o_pc_1,
    output logic [PWIDTH-1:0]        fq_o_pc_2,
    input  logic                     fq_i_pop_1,
    input  logic                     fq_i_pop_2,
    input  logic                     fq_i_flush,
    output logic [$clog2(DEPTH):0]   fq_o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [PWIDTH-1:0] r_pc    [DEPTH];
    logic [IWIDTH-1:0] r_instr [DEPTH];
    logic [AW-1:0]     w_rd_ptr;
    logic [AW-1:0]     w_rd_ptr_1;
    logic [AW-1:0]     w_wr_ptr;
    logic [AW-1:0]     w_wr_ptr_1;
    logic [AW:0]       w_count;
    logic              w_push_1;
    logic              w_push_2;

    fq_ptr_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ptr_ctrl (
        .i_clk     (fq_clk),
        .i_rst     (fq_rst),
        .i_valid_1 (fq_i_valid_1),
        .i_valid_2 (fq_i_valid_2),
        .i_pop_1   (fq_i_pop_1),
        .i_pop_2   (fq_i_pop_2),
        .i_flush   (fq_i_flush),
        .o_rd_ptr  (w_rd_ptr),
        .o_wr_ptr  (w_wr_ptr),
        .o_count   (w_count),
        .o_ready   (fq_o_ready),
        .o_push_1  (w_push_1),
        .o_push_2  (w_push_2)
    );

    assign w_wr_ptr_1 = w_wr_ptr + AW'(1);
    assign w_rd_ptr_1 = w_rd_ptr + AW'(1);

    // Storage is not reset; the count alone decides which entries are meaningful.
    // A write during flush is harmless because the pointers return to 0 regardless.
    always_ff @(posedge fq_clk) begin
        if (w_push_1) begin
            r_pc[w_wr_ptr]    <= fq_i_pc_1;
            r_instr[w_wr_ptr] <= fq_i_instr_1;
        end
        if (w_push_2) begin
            r_pc[w_wr_ptr_1]    <= fq_i_pc_2;
            r_instr[w_wr_ptr_1] <= fq_i_instr_2;
        end
    end

    assign fq_o_valid_1 = (w_count != '0);
    assign fq_o_valid_2 = (w_count >= (AW+1)'(2));
    assign fq_o_pc_1    = fq_o_valid_1 ? r_pc[w_rd_ptr]      : '0;
    assign fq_o_instr_1 = fq_o_valid_1 ? r_instr[w_rd_ptr]   : '0;
    assign fq_o_pc_2    = fq_o_valid_2 ? r_pc[w_rd_ptr_1]    : '0;
    assign fq_o_instr_2 = fq_o_valid_2 ? r_instr[w_rd_ptr_1] : '0;
    assign fq_o_count   = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        fq_clk = 1'b0;
    logic        fq_rst = 1'b1;
    logic        fq_i_valid_1 = 1'b0;
    logic        fq_i_valid_2 = 1'b0;
    logic [31:0] fq_i_instr_1 = '0;
    logic [31:0] fq_i_instr_2 = '0;
    logic [31:0] fq_i_pc_1 = '0;
    logic [31:0] fq_i_pc_2 = '0;
    logic        fq_o_ready;
    logic        fq_o_valid_1;
    logic        fq_o_valid_2;
    logic [31:0] fq_o_instr_1;
    logic [31:0] fq_o_instr_2;
    logic [31:0] fq_o_pc_1;
    logic [31:0] fq_o_pc_2;
    logic        fq_i_pop_1 = 1'b0;
    logic        fq_i_pop_2 = 1'b0;
    logic        fq_i_flush = 1'b0;
    logic [3:0]  fq_o_count;

    int   total = 0;
    int   bad = 0;
    ent_t mq[$];

    fetch_queue #(
        .DEPTH  (DEPTH),
        .IWIDTH (32),
        .PWIDTH (32)
    ) dut (
        .fq_clk       (fq_clk),
        .fq_rst       (fq_rst),
        .fq_i_valid_1 (fq_i_valid_1),
        .fq_i_valid_2 (fq_i_valid_2),
        .fq_i_instr_1 (fq_i_instr_1),
        .fq_i_instr_2 (fq_i_instr_2),
        .fq_i_pc_1    (fq_i_pc_1),
        .fq_i_pc_2    (fq_i_pc_2),
        .fq_o_ready   (fq_o_ready),
        .fq_o_valid_1 (fq_o_valid_1),
        .fq_o_valid_2 (fq_o_valid_2),
        .fq_o_instr_1 (fq_o_instr_1),
        .fq_o_instr_2 (fq_o_instr_2),
        .fq_o_pc_1    (fq_o_pc_1),
        .fq_o_pc_2    (fq_o_pc_2),
        .fq_i_pop_1   (fq_i_pop_1),
        .fq_i_pop_2   (fq_i_pop_2),
        .fq_i_flush   (fq_i_flush),
        .fq_o_count   (fq_o_count)
    );

    always #5 fq_clk = ~fq_clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a plain FIFO of entries, size-limited pushes, all-or-nothing pops.
    task automatic modelStep(input logic v1, input logic v2, input logic [31:0] pc1,
                             input logic [31:0] i1, input logic [31:0] pc2, input logic [31:0] i2,
                             input logic p1, input logic p2, input logic fl);
        int sz;
        int nPop;
        sz = mq.size();
        if (fl) begin
            mq.delete();
        end else begin
            nPop = 0;
            if (p1 && p2) nPop = (sz >= 2) ? 2 : 0;
            else if (p1) nPop = (sz >= 1) ? 1 : 0;
            for (int k = 0; k < nPop; k++) void'(mq.pop_front());
            if (v1 && (DEPTH - sz >= 2)) begin
                mq.push_back('{pc: pc1, instr: i1});
                if (v2) mq.push_back('{pc: pc2, instr: i2});
            end
        end
    endtask

    task automatic applyStimulus(input logic v1, input logic v2, input logic [31:0] pc1,
                                 input logic [31:0] i1, input logic [31:0] pc2, input logic [31:0] i2,
                                 input logic p1, input logic p2, input logic fl);
        @(negedge fq_clk);
        fq_i_valid_1 = v1;
        fq_i_valid_2 = v2;
        fq_i_pc_1    = pc1;
        fq_i_instr_1 = i1;
        fq_i_pc_2    = pc2;
        fq_i_instr_2 = i2;
        fq_i_pop_1   = p1;
        fq_i_pop_2   = p2;
        fq_i_flush   = fl;
        @(posedge fq_clk);
        modelStep(v1, v2, pc1, i1, pc2, i2, p1, p2, fl);
        #1;
    endtask

    task automatic pushPair(input logic [31:0] pc, input logic p1, input logic p2);
        applyStimulus(1'b1, 1'b1, pc, pc ^ 32'hC0DE0000, pc + 32'd4, (pc + 32'd4) ^ 32'hC0DE0000,
                      p1, p2, 1'b0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Every cycle the outputs are compared against what the model's FIFO contents imply.
    always @(negedge fq_clk) begin
        int sz;
        sz = mq.size();
        checkOutput("count", 64'(fq_o_count), 64'(sz));
        checkOutput("ready", 64'(fq_o_ready), 64'(DEPTH - sz >= 2));
        checkOutput("valid_1", 64'(fq_o_valid_1), 64'(sz >= 1));
        checkOutput("valid_2", 64'(fq_o_valid_2), 64'(sz >= 2));
        checkOutput("pc_1", 64'(fq_o_pc_1), (sz >= 1) ? 64'(mq[0].pc) : 64'd0);
        checkOutput("instr_1", 64'(fq_o_instr_1), (sz >= 1) ? 64'(mq[0].instr) : 64'd0);
        checkOutput("pc_2", 64'(fq_o_pc_2), (sz >= 2) ? 64'(mq[1].pc) : 64'd0);
        checkOutput("instr_2", 64'(fq_o_instr_2), (sz >= 2) ? 64'(mq[1].instr) : 64'd0);
    end

    initial begin
        logic v1, v2, p1, p2, fl;
        logic [31:0] pcR;

        @(negedge fq_clk);
        #2 fq_rst = 1'b0;
        checkOutput("reset_count", 64'(fq_o_count), 64'd0);
        checkOutput("reset_ready", 64'(fq_o_ready), 64'd1);

        applyStimulus(1'b1, 1'b1, 32'd0, 32'h20080005, 32'd4, 32'h20090003, 1'b0, 1'b0, 1'b0);
        checkOutput("first_valid_1", 64'(fq_o_valid_1), 64'd1);
        checkOutput("first_valid_2", 64'(fq_o_valid_2), 64'd1);
        checkOutput("first_pc_1", 64'(fq_o_pc_1), 64'd0);
        checkOutput("first_instr_1", 64'(fq_o_instr_1), 64'h20080005);
        checkOutput("first_pc_2", 64'(fq_o_pc_2), 64'd4);
        checkOutput("first_instr_2", 64'(fq_o_instr_2), 64'h20090003);
        checkOutput("first_count", 64'(fq_o_count), 64'd2);
        checkOutput("first_ready", 64'(fq_o_ready), 64'd1);

        for (int k = 1; k < 4; k++) pushPair(32'(8 * k), 1'b0, 1'b0);
        checkOutput("full_count", 64'(fq_o_count), 64'd8);
        checkOutput("full_ready", 64'(fq_o_ready), 64'd0);
        pushPair(32'd32, 1'b0, 1'b0);
        checkOutput("dropped_count", 64'(fq_o_count), 64'd8);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("pop1_count", 64'(fq_o_count), 64'd7);
        checkOutput("pop1_ready", 64'(fq_o_ready), 64'd0);
        checkOutput("pop1_head", 64'(fq_o_pc_1), 64'd4);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        checkOutput("pop2_count", 64'(fq_o_count), 64'd5);
        checkOutput("pop2_head", 64'(fq_o_pc_1), 64'd12);

        applyStimulus(1'b1, 1'b1, 32'd200, 32'h1, 32'd204, 32'h2, 1'b1, 1'b0, 1'b1);
        checkOutput("flush_count", 64'(fq_o_count), 64'd0);
        checkOutput("flush_valid_1", 64'(fq_o_valid_1), 64'd0);
        checkOutput("flush_pc_1", 64'(fq_o_pc_1), 64'd0);
        checkOutput("flush_instr_2", 64'(fq_o_instr_2), 64'd0);

        pushPair(32'd0, 1'b0, 1'b0);
        pushPair(32'd8, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) pushPair(32'(16 + 8 * k), 1'b1, 1'b1);
        checkOutput("steady_count", 64'(fq_o_count), 64'd4);
        checkOutput("steady_head", 64'(fq_o_pc_1), 64'd160);
        checkOutput("steady_next", 64'(fq_o_pc_2), 64'd164);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b0, 32'd12, 32'hAAAA0012, 32'd99, 32'd99, 1'b0, 1'b0, 1'b0);
        checkOutput("single_count", 64'(fq_o_count), 64'd1);
        checkOutput("single_valid_2", 64'(fq_o_valid_2), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        checkOutput("pairpop_one_count", 64'(fq_o_count), 64'd1);
        checkOutput("pairpop_one_head", 64'(fq_o_pc_1), 64'd12);
        applyStimulus(1'b1, 1'b0, 32'd16, 32'hAAAA0016, '0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("pop2_alone_count", 64'(fq_o_count), 64'd2);
        applyStimulus(1'b0, 1'b1, 32'd50, 32'd50, 32'd54, 32'd54, 1'b0, 1'b0, 1'b0);
        checkOutput("v2_alone_count", 64'(fq_o_count), 64'd2);

        pushPair(32'd20, 1'b0, 1'b0);
        pushPair(32'd28, 1'b0, 1'b0);
        checkOutput("prereset_count", 64'(fq_o_count), 64'd6);
        idle();
        #2 fq_rst = 1'b1;
        #1;
        checkOutput("async_count", 64'(fq_o_count), 64'd0);
        checkOutput("async_ready", 64'(fq_o_ready), 64'd1);
        checkOutput("async_valid_1", 64'(fq_o_valid_1), 64'd0);
        checkOutput("async_pc_1", 64'(fq_o_pc_1), 64'd0);
        checkOutput("async_instr_2", 64'(fq_o_instr_2), 64'd0);
        mq.delete();
        #1 fq_rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'd100, 32'hBEEF0100, 32'd104, 32'hBEEF0104, 1'b0, 1'b0, 1'b0);
        checkOutput("postreset_pc_1", 64'(fq_o_pc_1), 64'd100);
        checkOutput("postreset_instr_2", 64'(fq_o_instr_2), 64'hBEEF0104);
        checkOutput("postreset_count", 64'(fq_o_count), 64'd2);

        pcR = 32'h1000;
        for (int k = 0; k < 400; k++) begin
            v1 = ($urandom_range(0, 3) != 0);
            v2 = $urandom_range(0, 1) == 1;
            p1 = ($urandom_range(0, 2) != 0);
            p2 = $urandom_range(0, 1) == 1;
            fl = ($urandom_range(0, 24) == 0);
            applyStimulus(v1, v2, pcR, $urandom, pcR + 32'd4, $urandom, p1, p2, fl);
            pcR = pcR + 32'd8;
        end

        idle();
        @(negedge fq_clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
